// File: rtl/fft_input_loader.sv
// fft_input_loader: collects one complex sample per handshake into a 32-slot
// bit-reversed frame buffer, zero-pads short frames and holds the frame until acked.
module fft_input_loader #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    in_real_i,
  input  logic [WIDTH-1:0]    in_imag_i,
  input  logic                in_last_i,
  output logic [WIDTH*32-1:0] frame_real_o,
  output logic [WIDTH*32-1:0] frame_imag_o,
  output logic                frame_valid_o,
  input  logic                frame_ack_i,
  output logic                len_err_o
);
  localparam int N = 32;
  localparam int LOG2N = $clog2(N);
  localparam logic [1:0] FILL = 2'd0, PAD = 2'd1, FULL = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [LOG2N-1:0]   idx_q, idx_d, slot;
  logic [N*WIDTH-1:0] re_q, im_q;
  logic               len_err_q, len_err_d, acc, wr, last, ack;
  always_comb begin
    acc       = in_valid_i & (state_q == FILL);
    ack       = frame_ack_i & (state_q == FULL);
    last      = idx_q == LOG2N'(N - 1);
    wr        = acc | (state_q == PAD);
    slot      = {idx_q[0], idx_q[1], idx_q[2], idx_q[3], idx_q[4]};
    state_d   = acc ? (last ? FULL : in_last_i ? PAD : FILL)
              : (state_q == PAD && last) ? FULL
              : ack ? FILL : state_q;
    idx_d     = ack ? '0 : (wr && !last) ? idx_q + 1'b1 : idx_q;
    len_err_d = acc & last & ~in_last_i;
  end
  // PAD writes zeros through the same slot port used for samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      idx_q     <= '0;
      re_q      <= '0;
      im_q      <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_err_q <= len_err_d;
      if (wr) begin
        re_q[slot*WIDTH +: WIDTH] <= acc ? in_real_i : '0;
        im_q[slot*WIDTH +: WIDTH] <= acc ? in_imag_i : '0;
      end
    end
  end
  assign in_ready_o    = state_q == FILL;
  assign frame_valid_o = state_q == FULL;
  assign len_err_o     = len_err_q;
  assign frame_real_o  = re_q;
  assign frame_imag_o  = im_q;
endmodule
